// File: rtl/stopwatch_btn_ctrl_pkg.sv
// Stopwatch button control: shared FSM state and button index constants.
// Imported by the button front end and the run-control FSM.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;

endpackage

// File: rtl/stopwatch_btn_ctrl_if.sv
// Stopwatch control bundle: raw buttons in, run/lap/clear/debug out.
// master = the controller, slave = the button/counter/display side.
interface stopwatch_btn_ctrl_if;

  logic [1:0] btn;
  logic       run;
  logic       lap_hold;
  logic       clear_p;
  logic [1:0] btn_pedge;
  logic [1:0] state;

  modport master (
    input  btn,
    output run,
    output lap_hold,
    output clear_p,
    output btn_pedge,
    output state
  );

  modport slave (
    output btn,
    input  run,
    input  lap_hold,
    input  clear_p,
    input  btn_pedge,
    input  state
  );

endinterface

// File: rtl/stopwatch_btn_ctrl_debounce.sv
// One-button conditioner: 2-FF sync, debounce counter, press-edge pulse.
// Ports: clk, reset_p (sync, active-high), btn_raw in, pedge out.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic btn_raw,
  output logic pedge
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
      pedge   <= 1'b0;
    end else begin
      s1      <= btn_raw;
      s2      <= s1;
      // Any return to the accepted level restarts the count.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      db_prev <= db;
      pedge   <= db & ~db_prev;
    end
  end

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch run-control FSM fed by two debounced buttons.
// Ports: clk, reset_p (sync, active-high), bus (master: btn in, outputs).
module stopwatch_btn_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic                 clk,
  input  logic                 reset_p,
  stopwatch_btn_ctrl_if.master bus
);

  logic [1:0] pedge;
  state_t     st_q;
  state_t     st_d;
  logic       clr_d;
  logic       run_q;
  logic       lap_q;
  logic       clr_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_start (
    .clk    (clk),
    .reset_p(reset_p),
    .btn_raw(bus.btn[BTN_START]),
    .pedge  (pedge[BTN_START])
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_lap (
    .clk    (clk),
    .reset_p(reset_p),
    .btn_raw(bus.btn[BTN_LAP]),
    .pedge  (pedge[BTN_LAP])
  );

  // Start/stop is tested first so it wins over a same-cycle lap press.
  always_comb begin
    st_d  = st_q;
    clr_d = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (pedge[BTN_START]) st_d = ST_RUN;
      end
      ST_RUN: begin
        if (pedge[BTN_START])    st_d = ST_PAUSE;
        else if (pedge[BTN_LAP]) st_d = ST_LAP;
      end
      ST_LAP: begin
        if (pedge[BTN_START])    st_d = ST_PAUSE;
        else if (pedge[BTN_LAP]) st_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (pedge[BTN_START]) begin
          st_d = ST_RUN;
        end else if (pedge[BTN_LAP]) begin
          st_d  = ST_IDLE;
          clr_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they move with state.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      st_q  <= ST_IDLE;
      run_q <= 1'b0;
      lap_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      run_q <= (st_d == ST_RUN) || (st_d == ST_LAP);
      lap_q <= (st_d == ST_LAP);
      clr_q <= clr_d;
    end
  end

  assign bus.run       = run_q;
  assign bus.lap_hold  = lap_q;
  assign bus.clear_p   = clr_q;
  assign bus.btn_pedge = pedge;
  assign bus.state     = st_q;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Scoreboard bench for stopwatch_btn_ctrl with DEBOUNCE_CYCLES=4.
// Expected pulses/state changes are queued at stimulus, checked on output.
module tb_stopwatch_btn_ctrl;
  import stopwatch_pkg::*;

  localparam int N = 4;

  typedef struct {
    int         cyc;
    logic [1:0] pe;
  } pe_ev_t;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       run;
    logic       lap;
    logic       clr;
  } st_ev_t;

  logic clk = 1'b0;
  logic reset_p;
  int   cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  pe_ev_t peq[$];
  st_ev_t stq[$];

  logic [1:0] mst;
  logic [1:0] prev_st;
  logic       mon_en = 1'b0;
  int         clr_seen = 0;
  int         clr_exp = 0;

  stopwatch_btn_ctrl_if bus ();

  stopwatch_btn_ctrl #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference transition table: returns {clear, next_state}.
  function automatic logic [2:0] model(input logic [1:0] s,
                                       input logic [1:0] p);
    logic [2:0] r;
    r = {1'b0, s};
    case (s)
      ST_IDLE:  if (p[0]) r = {1'b0, ST_RUN};
      ST_RUN:   if (p[0]) r = {1'b0, ST_PAUSE};
                else if (p[1]) r = {1'b0, ST_LAP};
      ST_LAP:   if (p[0]) r = {1'b0, ST_PAUSE};
                else if (p[1]) r = {1'b0, ST_RUN};
      ST_PAUSE: if (p[0]) r = {1'b0, ST_RUN};
                else if (p[1]) r = {1'b1, ST_IDLE};
      default:  r = {1'b0, s};
    endcase
    return r;
  endfunction

  task automatic expect_st(input int at, input logic [1:0] ns,
                           input logic c);
    st_ev_t e;
    e.cyc = at;
    e.st  = ns;
    e.run = (ns == ST_RUN) || (ns == ST_LAP);
    e.lap = (ns == ST_LAP);
    e.clr = c;
    stq.push_back(e);
  endtask

  // Raise the masked buttons for hold cycles; edge 0 is the next posedge.
  task automatic press(input logic [1:0] m, input int hold);
    int         e0;
    logic [2:0] r;
    pe_ev_t     pe;
    @(negedge clk);
    bus.btn = bus.btn | m;
    e0 = cyc + 1;
    pe.cyc = e0 + N + 2;
    pe.pe  = m;
    peq.push_back(pe);
    r = model(mst, m);
    if (r[1:0] != mst || r[2]) expect_st(e0 + N + 3, r[1:0], r[2]);
    mst = r[1:0];
    if (r[2]) clr_exp++;
    repeat (hold) @(negedge clk);
    bus.btn = bus.btn & ~m;
    repeat (N + 8) @(negedge clk);
  endtask

  task automatic glitch(input logic [1:0] m, input int len);
    @(negedge clk);
    bus.btn = bus.btn | m;
    repeat (len) @(negedge clk);
    bus.btn = bus.btn & ~m;
    repeat (N + 8) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.btn_pedge != 2'b00) begin
        if (peq.size() == 0) begin
          chk("pedge_unexpected", int'(bus.btn_pedge), 0);
        end else begin
          pe_ev_t p;
          p = peq.pop_front();
          chk("pedge_val", int'(bus.btn_pedge), int'(p.pe));
          chk("pedge_cyc", cyc, p.cyc);
        end
      end
      if (bus.clear_p) clr_seen++;
      if (bus.state != prev_st) begin
        if (stq.size() == 0) begin
          chk("state_unexpected", int'(bus.state), int'(prev_st));
        end else begin
          st_ev_t s;
          s = stq.pop_front();
          chk("state_val", int'(bus.state), int'(s.st));
          chk("state_cyc", cyc, s.cyc);
          chk("run", int'(bus.run), int'(s.run));
          chk("lap_hold", int'(bus.lap_hold), int'(s.lap));
          chk("clear_p", int'(bus.clear_p), int'(s.clr));
        end
      end
      prev_st = bus.state;
    end
  end

  initial begin
    int r;
    reset_p = 1'b1;
    bus.btn = 2'b00;
    mst     = ST_IDLE;
    repeat (2) @(negedge clk);
    reset_p = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_state", int'(bus.state), 0);
      chk("idle_outs", int'({bus.run, bus.lap_hold, bus.clear_p,
                             bus.btn_pedge}), 0);
    end
    prev_st = bus.state;
    mon_en  = 1'b1;

    // 2: clean start, long hold gives one event
    press(2'b01, 60);
    chk("run_after_start", int'(bus.run), 1);

    // 3: short glitch rejected, 4-cycle press accepted
    glitch(2'b10, 3);
    chk("glitch_state", int'(bus.state), int'(ST_RUN));
    press(2'b10, 4);
    chk("lap_hold_on", int'(bus.lap_hold), 1);

    // 4: lap cycle, pause, clear
    press(2'b10, 12);
    press(2'b10, 12);
    press(2'b01, 12);
    press(2'b10, 12);
    chk("idle_after_clear", int'(bus.state), int'(ST_IDLE));

    // 5: simultaneous presses from RUN
    press(2'b01, 12);
    press(2'b11, 12);
    chk("simul_state", int'(bus.state), int'(ST_PAUSE));

    // 6: reset in LAP mid-debounce, held button re-accepted
    press(2'b01, 12);
    press(2'b10, 12);
    @(negedge clk);
    bus.btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b1;
    expect_st(cyc + 1, ST_IDLE, 1'b0);
    mst = ST_IDLE;
    @(negedge clk);
    reset_p = 1'b0;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_outs", int'({bus.run, bus.lap_hold, bus.clear_p,
                          bus.btn_pedge}), 0);
    begin
      pe_ev_t p;
      p.cyc = cyc + 1 + N + 2;
      p.pe  = 2'b01;
      peq.push_back(p);
      expect_st(cyc + 1 + N + 3, ST_RUN, 1'b0);
      mst = ST_RUN;
    end
    repeat (20) @(negedge clk);
    bus.btn = 2'b00;
    repeat (20) @(negedge clk);

    r = peq.size();
    chk("pedge_pending", r, 0);
    r = stq.size();
    chk("state_pending", r, 0);
    chk("clear_count", clr_seen, clr_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_btn_ctrl.md
# stopwatch_btn_ctrl

Button front end and run-control state machine for the stopwatch. Takes the two raw push-buttons, synchronises and debounces each one, and detects press edges. Drives a four-state control FSM whose outputs feed the stopwatch counters (`run`, `clear_p`) and the display path (`lap_hold`). It sits directly upstream of the seconds counter and the 4-digit FND controller.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_250_000: clocks a synchronised level must stay stable before it is accepted (10 ms at 125 MHz). Must be ≥ 2.

Ports:
- `clk` input 1: system clock; the only clock in the block.
- `reset_p` input 1: reset, synchronous and active-high.
- `btn` input 2: raw, asynchronous, active-high buttons. `btn[0]` is start/stop; `btn[1]` is lap/clear.
- `run` output 1: count enable for the stopwatch counters.
- `lap_hold` output 1: high means the display freezes its last latched value.
- `clear_p` output 1: one-cycle pulse that zeroes the counters.
- `btn_pedge` output 2: one-cycle debounced press pulses, for debug and reuse.
- `state` output 2: current FSM state, for debug.

## Operation
Per button, the conditioning chain is:
- A 2-FF synchroniser produces `s2`.
- A debounce counter compares `s2` with the accepted level `db`:
  - If they are equal, the counter is cleared to 0.
  - If they differ and the counter is below `DEBOUNCE_CYCLES-1`, the counter increments.
  - If they differ and the counter equals `DEBOUNCE_CYCLES-1`, then `db <= s2` and the counter clears.
- An edge register produces `btn_pedge[i] = db & ~db_prev`, registered, one cycle wide. Releases generate no event.

FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3. Transitions are evaluated on `btn_pedge`:
- IDLE: start/stop goes to RUN. Lap/clear is ignored.
- RUN: start/stop goes to PAUSE. Lap/clear goes to LAP.
- LAP: start/stop goes to PAUSE, and the freeze is released. Lap/clear goes to RUN, and the freeze is released.
- PAUSE: start/stop goes to RUN. Lap/clear goes to IDLE and fires `clear_p`.
- Both pulses in the same cycle: start/stop wins and the lap/clear pulse is discarded.

Outputs are registered and decoded from the next state, so they change on the same edge as `state`:
- `run` = 1 in RUN or LAP.
- `lap_hold` = 1 in LAP only.
- `clear_p` = 1 for exactly the one cycle following the PAUSE→IDLE transition edge.

## Timing
- Reset values: `state`=IDLE, and `run`, `lap_hold`, `clear_p`, `btn_pedge` all 0. The synchronisers, `db`, `db_prev` and the counters are 0.
- Reset takes effect on the first rising edge with `reset_p`=1 and applies even mid-debounce or mid-FSM. No output pulse is produced by reset itself.
- A button held through reset release is accepted as a fresh press once debounced.
- Latency: take edge 0 as the first edge sampling the new raw level.
  - `db` updates at edge `DEBOUNCE_CYCLES+1`.
  - `btn_pedge` is high after edge `DEBOUNCE_CYCLES+2`.
  - `state`, `run` and `lap_hold` change at edge `DEBOUNCE_CYCLES+3`.
- Glitch rejection: any raw excursion stable for fewer than `DEBOUNCE_CYCLES` synchronised cycles is discarded, and the counter restarts from 0.
- Holding a button produces exactly one event. No auto-repeat.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never wraps, because it saturates at `DEBOUNCE_CYCLES-1` and clears.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the state constants ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP (2-bit);
  - the button index constants BTN_START=0, BTN_LAP=1.
- Sub-module `btn_debounce` contains the synchroniser, debounce counter and edge register, with parameter `DEBOUNCE_CYCLES`. It is instantiated twice.
- The top level contains only the FSM and the output registers.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES=4`.
1. Reset then idle: hold `reset_p` for 2 cycles, with `btn`=0 for 20 cycles → all outputs 0 and `state`=0 throughout.
2. Clean start: `btn[0]` goes 0→1 and is held → `btn_pedge[0]` is high for 1 cycle after edge 6, and `run`=1 and `state`=1 from edge 7. Holding for a further 50 cycles produces no further pulse.
3. Glitch: a 3-cycle high pulse on `btn[1]` while in RUN → no `btn_pedge`, and `state` stays 1. A 4-cycle pulse → LAP with `lap_hold`=1.
4. Full cycle: RUN → lap press (LAP, `run`=1, `lap_hold`=1) → start/stop press (PAUSE, `run`=0, `lap_hold`=0) → lap press → IDLE with `clear_p` high for exactly 1 cycle.
5. Simultaneous presses: both buttons rise in the same cycle from RUN → PAUSE, with no LAP entry and no `clear_p`.
6. Reset mid-operation: assert `reset_p` for 1 cycle in LAP, midway through a debounce → the next edge shows `state`=0, and `run`, `lap_hold`, `clear_p` = 0. A button still held afterwards yields one press 7 edges after reset release.
